// File: rtl/bscan_pkg.sv
// Shared types for the Bscan word gatherer: FSM states, default frame marker, header type.
package bscan_pkg;

  typedef enum logic [1:0] {HUNT, PAYLOAD, HOLD} state_t;

  localparam logic [15:0] BSCAN_SYNC = 16'hA5C3;

  typedef logic [15:0] hdr_t;

endpackage

// File: rtl/bscan_gather.sv
// Reassembles Bscan 32-bit words into header+payload messages; message valid 1 cycle after last word.
// Input stalls only in HOLD, when a finished message waits behind an unaccepted output.
module bscan_gather
  import bscan_pkg::*;
#(
  parameter logic [15:0] SYNC          = BSCAN_SYNC,
  parameter int unsigned PAYLOAD_WORDS = 4
) (
  input  logic                            CLK,
  input  logic                            nRST,
  input  logic                            in_enq__ENA,
  input  logic [31:0]                     in_enq_v,
  output logic                            in_enq__RDY,
  output logic                            out_enq__ENA,
  output logic [16+32*PAYLOAD_WORDS-1:0]  out_enq_v,
  input  logic                            out_enq__RDY,
  output logic [7:0]                      syncErrors
);

  localparam int unsigned MSGW = 16 + 32*PAYLOAD_WORDS;
  localparam int unsigned CNTW = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(PAYLOAD_WORDS - 1);

  state_t          state_q, state_nxt;
  logic [CNTW-1:0] cnt_q;
  logic [MSGW-1:0] asm_q, asm_nxt, out_q;
  logic            out_vld_q;
  logic [7:0]      err_q;
  logic            word_xfer, out_free, is_sync, is_last, load_out;
  hdr_t            word_hdr;

  assign in_enq__RDY = (state_q != HOLD);
  assign word_xfer   = in_enq__ENA & in_enq__RDY;
  assign out_free    = ~out_vld_q | out_enq__RDY;
  assign is_sync     = (in_enq_v[31:16] == SYNC);
  assign is_last     = (cnt_q == LAST);
  assign word_hdr    = in_enq_v[15:0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= HUNT;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    load_out  = 1'b0;
    case (state_q)
      HUNT: begin
        if (word_xfer && is_sync) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        if (word_xfer && is_last) begin
          if (out_free) begin
            state_nxt = HUNT;
            load_out  = 1'b1;
          end else begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          state_nxt = HUNT;
          load_out  = 1'b1;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // The output register loads from asm_nxt so the last payload word lands in the same cycle.
  always_comb begin
    asm_nxt = asm_q;
    if (word_xfer) begin
      if (state_q == HUNT && is_sync)
        asm_nxt[15:0] = word_hdr;
      else if (state_q == PAYLOAD)
        asm_nxt[16 + 32*int'(cnt_q) +: 32] = in_enq_v;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      asm_q     <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      asm_q <= asm_nxt;
      if (state_q == HUNT && word_xfer && is_sync)
        cnt_q <= '0;
      else if (state_q == PAYLOAD && word_xfer)
        cnt_q <= cnt_q + CNTW'(1);
      if (state_q == HUNT && word_xfer && !is_sync && err_q != 8'hFF)
        err_q <= err_q + 8'd1;
      if (load_out) begin
        out_q     <= asm_nxt;
        out_vld_q <= 1'b1;
      end else if (out_enq__RDY) begin
        out_vld_q <= 1'b0;
      end
    end
  end

  assign out_enq__ENA = out_vld_q;
  assign out_enq_v    = out_q;
  assign syncErrors   = err_q;

endmodule

// File: tb/tb_bscan_gather.sv
// Bench for bscan_gather: word table with expected error counts, message scoreboard, stall/reset sequences.
module tb_bscan_gather;
  import bscan_pkg::*;

  localparam int PW   = 4;
  localparam int MSGW = 16 + 32*PW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_vld = 1'b0;
  logic [31:0]     in_dat = '0;
  logic            in_rdy;
  logic            out_vld;
  logic [MSGW-1:0] out_dat;
  logic            out_rdy = 1'b0;
  logic [7:0]      sync_err;

  always #5 clk = ~clk;

  bscan_gather #(.SYNC(16'hA5C3), .PAYLOAD_WORDS(PW)) dut (
    .CLK          (clk),
    .nRST         (rst_n),
    .in_enq__ENA  (in_vld),
    .in_enq_v     (in_dat),
    .in_enq__RDY  (in_rdy),
    .out_enq__ENA (out_vld),
    .out_enq_v    (out_dat),
    .out_enq__RDY (out_rdy),
    .syncErrors   (sync_err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_low = 0;
  bit watch_rdy = 1'b0;
  logic [MSGW-1:0] exp_q[$];
  int dlv_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [MSGW-1:0] act, input logic [MSGW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [MSGW-1:0] mk(input logic [15:0] hdr, input logic [31:0] p0,
                                         input logic [31:0] p1, input logic [31:0] p2,
                                         input logic [31:0] p3);
    return {p3, p2, p1, p0, hdr};
  endfunction

  // Scoreboard: every accepted message must match the oldest expected one.
  always @(negedge clk) begin
    if (watch_rdy && !in_rdy) rdy_low++;
    if (rst_n && out_vld && out_rdy) begin
      dlv_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_msg: got %h want none", out_dat);
      end else begin
        chk("msg", out_dat, exp_q.pop_front());
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    in_vld = 1'b1;
    in_dat = w;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      total++;
      bad++;
      $display("FAIL send_timeout: word %h not accepted, want accepted", w);
    end
    in_vld = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] hdr, input logic [31:0] base);
    exp_q.push_back(mk(hdr, base + 1, base + 2, base + 3, base + 4));
    send_word({16'hA5C3, hdr});
    for (int k = 1; k <= PW; k++) send_word(base + k);
  endtask

  task automatic do_reset();
    in_vld = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: pending=%0d want 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] w;
    logic [7:0]  err;
    logic        ena;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [MSGW-1:0] f1, f2;

    tbl[0]  = '{32'hA5C3_0012, 8'd0, 1'b0};
    tbl[1]  = '{32'h1111_1111, 8'd0, 1'b0};
    tbl[2]  = '{32'h2222_2222, 8'd0, 1'b0};
    tbl[3]  = '{32'h3333_3333, 8'd0, 1'b0};
    tbl[4]  = '{32'h4444_4444, 8'd0, 1'b1};
    tbl[5]  = '{32'h0000_0001, 8'd1, 1'b0};
    tbl[6]  = '{32'hDEAD_BEEF, 8'd2, 1'b0};
    tbl[7]  = '{32'hA5C3_0077, 8'd2, 1'b0};
    tbl[8]  = '{32'h0A0A_0A0A, 8'd2, 1'b0};
    tbl[9]  = '{32'h0B0B_0B0B, 8'd2, 1'b0};
    tbl[10] = '{32'h0C0C_0C0C, 8'd2, 1'b0};
    tbl[11] = '{32'h0D0D_0D0D, 8'd2, 1'b1};

    do_reset();
    chk("rst_ena", out_vld, 0);
    chk("rst_dat", out_dat, 0);
    chk("rst_err", sync_err, 0);
    chk("rst_rdy", in_rdy, 1);

    // Basic framing and sync-error counting
    out_rdy = 1'b1;
    exp_q.push_back({128'h44444444_33333333_22222222_11111111, 16'h0012});
    exp_q.push_back(mk(16'h0077, 32'h0A0A_0A0A, 32'h0B0B_0B0B, 32'h0C0C_0C0C, 32'h0D0D_0D0D));
    for (int i = 0; i < 12; i++) begin
      send_word(tbl[i].w);
      chk($sformatf("tbl_err[%0d]", i), sync_err, tbl[i].err);
      chk($sformatf("tbl_ena[%0d]", i), out_vld, tbl[i].ena);
    end
    drain();

    // Saturation
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send_word(32'h1234_0000 + i);
      if (i == 253) chk("sat_254", sync_err, 254);
    end
    chk("sat_255", sync_err, 255);

    // Stalled consumer: frame 1 held in output, frame 2 held in assembly
    do_reset();
    out_rdy = 1'b0;
    f1 = mk(16'h0101, 32'h1000_0001, 32'h1000_0002, 32'h1000_0003, 32'h1000_0004);
    f2 = mk(16'h0202, 32'h2000_0001, 32'h2000_0002, 32'h2000_0003, 32'h2000_0004);
    send_frame(16'h0101, 32'h1000_0000);
    chk("stall_ena", out_vld, 1);
    chk("stall_dat", out_dat, f1);
    send_frame(16'h0202, 32'h2000_0000);
    chk("hold_rdy", in_rdy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_stable", out_dat, f1);
    chk("hold_rdy2", in_rdy, 0);
    out_rdy = 1'b1;
    @(posedge clk);
    #1 out_rdy = 1'b0;
    chk("rel_ena", out_vld, 1);
    chk("rel_dat", out_dat, f2);
    chk("rel_rdy", in_rdy, 1);
    out_rdy = 1'b1;
    drain();

    // Back-to-back at full rate
    do_reset();
    out_rdy = 1'b1;
    dlv_q.delete();
    rdy_low = 0;
    watch_rdy = 1'b1;
    send_frame(16'h0A01, 32'h5000_0000);
    send_frame(16'h0A02, 32'h6000_0000);
    send_frame(16'h0A03, 32'h7000_0000);
    drain();
    watch_rdy = 1'b0;
    chk("b2b_count", dlv_q.size(), 3);
    if (dlv_q.size() == 3) begin
      chk("b2b_gap1", dlv_q[1] - dlv_q[0], 5);
      chk("b2b_gap2", dlv_q[2] - dlv_q[1], 5);
    end
    chk("b2b_rdy_low", rdy_low, 0);

    // Reset mid-message
    do_reset();
    out_rdy = 1'b1;
    send_word(32'hA5C3_00AA);
    send_word(32'h8000_0001);
    send_word(32'h8000_0002);
    rst_n = 1'b0;
    #3;
    chk("mid_rst_ena", out_vld, 0);
    chk("mid_rst_rdy", in_rdy, 1);
    chk("mid_rst_err", sync_err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send_frame(16'h00BB, 32'h3000_0000);
    drain();
    chk("post_rst_err", sync_err, 0);
    chk("post_rst_pending", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
